dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Responder side of the data-memory access interface: accepts single read/write requests from the
//  pipeline's MEM stage (address, write data, data_read/data_write strobes), services them against an
//  internal word array after a fixed number of wait states, and returns read data with a ready pulse.
//  Sits between the MEM-stage load/store logic and storage; all decode/error checks are local.
// PARAMETERS
//  DEPTH_WORDS  256  number of 32-bit words; power of two, >= 4
//  BASE_ADDR    32'h00000000  byte address of word 0; must be aligned to DEPTH_WORDS*4
//  WAIT_STATES  1    extra cycles between acceptance and response, 0..15
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous active-low reset
//  data_address   in   32  byte address of request
//  in_data_write  in   32  write data
//  byte_en        in   4   write lane enables, bit i -> bits [8i+7:8i]; ignored for reads
//  data_read      in   1   read request strobe
//  data_write     in   1   write request strobe
//  out_data       out  32  read data, valid when data_ready=1
//  data_ready     out  1   one-cycle response pulse (read or write complete)
//  data_error     out  1   qualifies data_ready: request rejected, no storage effect
//  busy           out  1   high from acceptance until the data_ready cycle inclusive
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, out_data=0, data_ready=0, data_error=0, busy=0.
//   Array contents are NOT cleared; reset mid-request abandons it (no write if not yet committed).
//  FSM IDLE -> WAIT -> RESP -> IDLE.
//   IDLE: if data_read|data_write on a clock edge, capture address/data/byte_en/op, go WAIT
//     (or RESP directly when WAIT_STATES=0); wait counter loaded with WAIT_STATES.
//   WAIT: counter decrements each cycle; at 1 -> RESP. Inputs ignored while not IDLE.
//   RESP: data_ready=1 for exactly this cycle; write committed to array on the edge entering RESP;
//     read data presented on out_data in RESP and held until next response.
//  Latency: request seen at edge N -> data_ready high in cycle N+1+WAIT_STATES.
//  Requester must drop strobes on the edge that samples data_ready; strobes still high in IDLE form a
//   new request (back-to-back throughput one access per WAIT_STATES+2 cycles).
//  Errors (data_error=1 with data_ready, out_data unchanged, array unchanged):
//   data_read & data_write both high; address outside [BASE_ADDR, BASE_ADDR+DEPTH_WORDS*4).
//  Index = (data_address-BASE_ADDR)>>2, width $clog2(DEPTH_WORDS); write with byte_en=0 completes OK, no-op.
//  Read of a word written in the immediately preceding access returns the new value.
// CONFIGURATION
//  DMEM_MISALIGN_CHECK_EN defined: data_address[1:0]!=0 -> error response, no access.
//  Not defined: data_address[1:0] ignored, access targets the containing word, no error.
// STRUCTURE
//  dmem_defs.vh (shared include): state encodings DMEM_IDLE/WAIT/RESP, op codes, width macros,
//   reused by the MEM-stage initiator and the bench.
//  Sub-module dmem_array: synchronous word RAM with per-byte write enables, async read port;
//   dmem_responder holds FSM, counter, decode and error logic.
// TESTING
//  1 Reset, write 32'h19283746 byte_en=4'hF to 0x0, then read 0x0 -> out_data=32'h19283746,
//    data_ready exactly 2 cycles after request (WAIT_STATES=1), data_error=0.
//  2 Write 32'hAABBCCDD to 0x8 then write 32'h11223344 byte_en=4'b0101 to 0x8, read -> 32'hAA22CC44.
//  3 data_read=data_write=1 at 0x4; and read at BASE_ADDR+DEPTH_WORDS*4 -> data_error=1 with
//    data_ready, out_data unchanged, later read of 0x4 returns its prior contents.
//  4 Read 0x6: with DMEM_MISALIGN_CHECK_EN -> data_error=1; without -> contents of word 0x4.
//  5 Assert rst_n=0 during WAIT of a write to 0xC -> outputs 0 immediately; after release read 0xC
//    returns old value; array contents at 0x0 preserved.
//  6 WAIT_STATES=0 and 3 builds: back-to-back held strobes -> data_ready every 2 / 5 cycles, busy exact.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder slice.
//   state_t : responder FSM states (IDLE -> WAIT -> RESP -> IDLE)
//   op_t    : captured request kind
//   WORD_BITS / LANES : data word width and number of byte lanes
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam int unsigned WORD_BITS = 32;
  localparam int unsigned LANES     = WORD_BITS / 8;

endpackage

// File: rtl/dmem_responder_array.sv
// Word RAM behind the data-memory responder.
// Synchronous write with per-byte lane enables, asynchronous read port.
// No reset: contents survive a responder reset.
// Ports:
//   clk   in  rising-edge clock
//   we    in  write enable (commits on the rising edge)
//   addr  in  word index, shared by read and write
//   wdata in  write data
//   wstrb in  byte lane enables, bit i -> wdata[8i+7:8i]
//   rdata out word at addr (combinational)
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned AW          = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        addr,
  input  logic [WORD_BITS-1:0] wdata,
  input  logic [LANES-1:0]     wstrb,
  output logic [WORD_BITS-1:0] rdata
);

  logic [WORD_BITS-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wstrb[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one read/write request from the MEM stage,
// waits WAIT_STATES cycles, then pulses data_ready (with data_error on a
// rejected request) and presents read data on out_data.
// Optional build macro: DMEM_MISALIGN_CHECK_EN -- when defined, a request
// with data_address[1:0] != 0 is rejected; otherwise the low bits are ignored.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   data_address    byte address of the request
//   in_data_write   write data
//   byte_en         write lane enables (ignored for reads)
//   data_read       read request strobe
//   data_write      write request strobe
//   out_data        read data, held until the next successful read response
//   data_ready      one-cycle response pulse
//   data_error      qualifies data_ready: request rejected, no storage effect
//   busy            high from acceptance through the data_ready cycle
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_address,
  input  logic [31:0] in_data_write,
  input  logic [3:0]  byte_en,
  input  logic        data_read,
  input  logic        data_write,
  output logic [31:0] out_data,
  output logic        data_ready,
  output logic        data_error,
  output logic        busy
);

  localparam int unsigned AW  = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  WS4 = 4'(WAIT_STATES);

  state_t        state;
  logic [3:0]    cnt;
  op_t           op_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;

  // Decode of the live request (only meaningful while IDLE)
  logic          req;
  logic [31:0]   in_off;
  logic          in_oor;
  logic          in_misalign;
  logic          in_err;
  logic [AW-1:0] in_idx;

  assign req    = data_read | data_write;
  assign in_off = data_address - BASE_ADDR;
  // BASE_ADDR is aligned to the array size, so any offset bit above the
  // word index means the address is outside the window (wrap included).
  assign in_oor = (in_off >> (AW + 2)) != '0;
  assign in_idx = in_off[AW+1:2];

`ifdef DMEM_MISALIGN_CHECK_EN
  assign in_misalign = in_off[1:0] != 2'b00;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^in_off[1:0];
  assign in_misalign     = 1'b0;
`endif

  assign in_err = (data_read & data_write) | in_oor | in_misalign;

  // With WAIT_STATES=0 the response is produced on the accepting edge, so the
  // RAM must see the live inputs in IDLE rather than the captured copies.
  logic          cur_err;
  logic          cur_rd;
  logic          cur_wr;
  logic [AW-1:0] cur_idx;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic          enter_resp;
  logic [31:0]   rdata;

  always_comb begin
    cur_err   = err_q;
    cur_rd    = (op_q == OP_READ) & ~err_q;
    cur_wr    = (op_q == OP_WRITE) & ~err_q;
    cur_idx   = idx_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == ST_IDLE) begin
      cur_err   = in_err;
      cur_rd    = data_read & ~in_err;
      cur_wr    = data_write & ~in_err;
      cur_idx   = in_idx;
      cur_wdata = in_data_write;
      cur_be    = byte_en;
    end
  end

  assign enter_resp = ((state == ST_IDLE) && req && (WAIT_STATES == 0)) ||
                      ((state == ST_WAIT) && (cnt == 4'd1));

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (enter_resp & cur_wr),
    .addr (cur_idx),
    .wdata(cur_wdata),
    .wstrb(cur_be),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      op_q       <= OP_READ;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      out_data   <= '0;
      data_ready <= 1'b0;
      data_error <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_ready <= 1'b0;
      data_error <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (req) begin
            op_q    <= data_write ? OP_WRITE : OP_READ;
            err_q   <= in_err;
            idx_q   <= in_idx;
            wdata_q <= in_data_write;
            be_q    <= byte_en;
            busy    <= 1'b1;
            state   <= ST_WAIT;
            cnt     <= WS4;
          end
        end
        ST_WAIT: cnt <= cnt - 4'd1;
        ST_RESP: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
      // Later assignment wins: covers both the WAIT exit and the
      // zero-wait-state path straight out of IDLE.
      if (enter_resp) begin
        state      <= ST_RESP;
        data_ready <= 1'b1;
        data_error <= cur_err;
        if (cur_rd) out_data <= rdata;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_address;
  logic [31:0] in_data_write;
  logic [3:0]  byte_en;
  logic        data_read;
  logic        data_write;

  // index 0: WAIT_STATES=1 (main), 1: WAIT_STATES=0, 2: WAIT_STATES=3
  logic [31:0] od [3];
  logic [2:0]  rdy;
  logic [2:0]  err;
  logic [2:0]  bsy;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] exp_out;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .data_address(data_address), .in_data_write(in_data_write),
    .byte_en(byte_en), .data_read(data_read), .data_write(data_write),
    .out_data(od[0]), .data_ready(rdy[0]), .data_error(err[0]), .busy(bsy[0]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n), .data_address(data_address), .in_data_write(in_data_write),
    .byte_en(byte_en), .data_read(data_read), .data_write(data_write),
    .out_data(od[1]), .data_ready(rdy[1]), .data_error(err[1]), .busy(bsy[1]));

  dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n), .data_address(data_address), .in_data_write(in_data_write),
    .byte_en(byte_en), .data_read(data_read), .data_write(data_write),
    .out_data(od[2]), .data_ready(rdy[2]), .data_error(err[2]), .busy(bsy[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One request on the WAIT_STATES=1 responder, checked against the model.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    int unsigned k;
    logic [31:0] off;
    logic        exp_err;
    int          idx;
    @(negedge clk);
    data_read = rd; data_write = wr; data_address = a; in_data_write = d; byte_en = be;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!rdy[0] && k < 20);
    data_read = 1'b0; data_write = 1'b0;

    off     = a - BASE;
    exp_err = (rd && wr) || (off >= DEPTH * 4);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) exp_err = 1'b1;
`endif
    idx = int'(off >> 2) % DEPTH;
    if (!exp_err && wr)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem_m[idx][8*i +: 8] = d[8*i +: 8];
    if (!exp_err && rd) exp_out = mem_m[idx];

    check_eq("ready", 32'(rdy[0]), 32'd1);
    check_eq("latency", 32'(k), 32'd2);
    check_eq("error", 32'(err[0]), 32'(exp_err));
    check_eq("out_data", od[0], exp_out);
    check_eq("busy_resp", 32'(bsy[0]), 32'd1);
    @(negedge clk);
    check_eq("ready_pulse", 32'(rdy[0]), 32'd0);
    check_eq("busy_idle", 32'(bsy[0]), 32'd0);
  endtask

  initial begin
    int          ws [3];
    int          r;
    logic [31:0] a;
    ws[0] = 1; ws[1] = 0; ws[2] = 3;
    rst_n = 1'b0; data_address = '0; in_data_write = '0; byte_en = '0;
    data_read = 1'b0; data_write = 1'b0; exp_out = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_out", od[0], 32'h0);
    check_eq("rst_ready", 32'(rdy[0]), 32'd0);
    check_eq("rst_error", 32'(err[0]), 32'd0);
    check_eq("rst_busy", 32'(bsy[0]), 32'd0);
    rst_n = 1'b1;

    // basic write then read
    access(1'b0, 1'b1, 32'h0, 32'h19283746, 4'hF);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("t1_data", od[0], 32'h19283746);

    // known contents everywhere
    for (int i = 0; i < int'(DEPTH); i++)
      access(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);

    // partial-lane write
    access(1'b0, 1'b1, 32'h8, 32'hAABBCCDD, 4'hF);
    access(1'b0, 1'b1, 32'h8, 32'h11223344, 4'b0101);
    access(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
    check_eq("t2_merge", od[0], 32'hAA22CC44);

    // rejected requests leave storage and out_data alone
    access(1'b1, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF);
    access(1'b1, 1'b0, BASE + DEPTH * 4, 32'h0, 4'h0);
    access(1'b0, 1'b1, BASE + DEPTH * 4, 32'h12345678, 4'hF);
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
    access(1'b0, 1'b1, 32'h10, 32'hCAFEF00D, 4'h0);
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);

    // misaligned read
    access(1'b1, 1'b0, 32'h6, 32'h0, 4'h0);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, DEPTH * 4 - 1));
      if (r == 9) a = $urandom | (DEPTH * 4);
      access(r < 4 || r >= 8, (r >= 4 && r < 8) || r == 8 || (r == 9 && a[4]), a,
             $urandom, 4'($urandom_range(0, 15)));
    end

    // reset while a write waits
    @(negedge clk);
    data_write = 1'b1; data_address = 32'hC; in_data_write = 32'h5A5A5A5A; byte_en = 4'hF;
    @(negedge clk);
    check_eq("t5_busy_wait", 32'(bsy[0]), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_out", od[0], 32'h0);
    check_eq("t5_rst_ready", 32'(rdy[0]), 32'd0);
    check_eq("t5_rst_busy", 32'(bsy[0]), 32'd0);
    data_write = 1'b0;
    exp_out = '0;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0);

    // held read strobe: response every WAIT_STATES+2 cycles on each build
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data_read = 1'b1; data_address = 32'h0;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        check_eq($sformatf("tp%0d_ready_c%0d", ws[d], c), 32'(rdy[d]),
                 32'((c % (ws[d] + 2)) == ws[d] + 1));
        check_eq($sformatf("tp%0d_busy_c%0d", ws[d], c), 32'(bsy[d]),
                 32'((c % (ws[d] + 2)) != 0));
      end
    end
    data_read = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("tp_out", od[0], mem_m[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
